mem_arbiter: RTL and testbench

Shares one single-port synchronous SRAM between the fetch stage (read-only instruction port) and the memory stage (read/write data port). It sits between the IF / ex_Mem_reg request sides and a unified RAM, grants at most one access per cycle, and routes the one-cycle-late read data back to the requester that issued the read. Data accesses have priority; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and unified SRAM port of mem_arbiter.
// The arbiter takes the slave view; the requesters/SRAM side takes master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch (instruction) port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Data (load/store) port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_mode;
  logic [2:0]        d_write_mode;
  logic              d_us;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Unified SRAM port
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [2:0]        sram_mode;
  logic [2:0]        sram_write_mode;
  logic              sram_us;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_mode, d_write_mode, d_us,
    input  sram_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    output sram_mode, sram_write_mode, sram_us
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_mode, d_write_mode, d_us,
    output sram_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_mode, sram_write_mode, sram_us
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch port and the
// data port. Data wins by default; a starvation counter lets fetch through
// after STARVE_MAX consecutive denied cycles. Read data returns one cycle
// after the grant and is steered to whichever port issued the read.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4   // 1..15
) (
  input  logic         clk,
  input  logic         reset,    // asynchronous, active low
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] starve_cnt;
  logic       if_win;
  logic       d_win;

  // Arbitration: fetch wins only when data is idle or fetch has starved long enough
  always_comb begin
    if_win     = bus.if_req && (!bus.d_req || (starve_cnt == STARVE_LIM));
    d_win      = bus.d_req && !if_win;
    bus.if_gnt = if_win;
    bus.d_gnt  = d_win;
  end

  // SRAM request mux: winner drives the port, all zeros when nobody wins
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    bus.sram_en         = 1'b0;
    bus.sram_we         = 1'b0;
    bus.sram_addr       = {ADDR_W{1'b0}};
    bus.sram_wdata      = {DATA_W{1'b0}};
    bus.sram_mode       = 3'b000;
    bus.sram_write_mode = 3'b000;
    bus.sram_us         = 1'b0;
    if (if_win) begin
      bus.sram_en   = 1'b1;
      bus.sram_addr = bus.if_addr;
      bus.sram_mode = 3'b010;            // instruction fetch is always a word
    end else if (d_win) begin
      bus.sram_en         = 1'b1;
      bus.sram_we         = bus.d_we;
      bus.sram_addr       = bus.d_addr;
      bus.sram_wdata      = bus.d_wdata;
      bus.sram_mode       = bus.d_mode;
      bus.sram_write_mode = bus.d_write_mode;
      bus.sram_us         = bus.d_us;
    end
  end

  // Starvation counter: counts consecutive denied fetch cycles, saturating
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: async active-low reset in the sensitivity list; state uses <= so all flops see pre-edge values.
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (!bus.if_req || if_win) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Response state register: remembers which port owns next cycle's read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response next state and read-data steering
  always_comb begin
    state_d = IDLE;
    if (if_win) begin
      state_d = RESP_IF;
    end else if (d_win && !bus.d_we) begin
      state_d = RESP_D;                  // writes produce no response
    end
    bus.if_rvalid = (state_q == RESP_IF);
    bus.d_rvalid  = (state_q == RESP_D);
    bus.if_rdata  = (state_q == RESP_IF) ? bus.sram_rdata : {DATA_W{1'b0}};
    bus.d_rdata   = (state_q == RESP_D)  ? bus.sram_rdata : {DATA_W{1'b0}};
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural word-addressed SRAM.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [31:0] mem [0:1023];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port SRAM: write on the edge, read data one cycle later
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we) mem[bus.sram_addr[11:2]] <= bus.sram_wdata;
      else             bus.sram_rdata <= mem[bus.sram_addr[11:2]];
    end
  end

  task automatic idle_inputs();
    bus.if_req       = 1'b0;
    bus.if_addr      = '0;
    bus.d_req        = 1'b0;
    bus.d_we         = 1'b0;
    bus.d_addr       = '0;
    bus.d_wdata      = '0;
    bus.d_mode       = 3'b000;
    bus.d_write_mode = 3'b000;
    bus.d_us         = 1'b0;
  endtask

  task automatic d_read(input logic [31:0] addr);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = addr;
    bus.d_mode = 3'b010; bus.d_write_mode = 3'b000; bus.d_us = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #3;
    n_checks++; if (bus.if_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_if_rvalid: got %b want 0", bus.if_rvalid); end
    n_checks++; if (bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_d_rvalid: got %b want 0", bus.d_rvalid); end
    n_checks++; if (bus.if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata: got %h want 0", bus.if_rdata); end
    n_checks++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h want 0", bus.d_rdata); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if ({bus.if_gnt, bus.d_gnt} !== 2'b00) begin n_fail++; $display("FAIL idle_gnts: got %b want 00", {bus.if_gnt, bus.d_gnt}); end
    n_checks++; if ({bus.sram_en, bus.sram_we, bus.sram_addr} !== 34'h0) begin n_fail++; $display("FAIL idle_sram: got en=%b we=%b addr=%h want all 0", bus.sram_en, bus.sram_we, bus.sram_addr); end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    #1;
    n_checks++; if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin n_fail++; $display("FAIL fetch_gnt: got if/d=%b want 10", {bus.if_gnt, bus.d_gnt}); end
    n_checks++; if (bus.sram_addr !== 32'h10 || bus.sram_en !== 1'b1 || bus.sram_we !== 1'b0 || bus.sram_mode !== 3'b010)
      begin n_fail++; $display("FAIL fetch_sram: got addr=%h en=%b we=%b mode=%b want 10 1 0 010", bus.sram_addr, bus.sram_en, bus.sram_we, bus.sram_mode); end
    @(negedge clk);
    bus.if_req = 1'b0;
    #1;
    n_checks++; if (bus.if_rvalid !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid: got %b want 1", bus.if_rvalid); end
    n_checks++; if (bus.if_rdata !== 32'h0010_0093) begin n_fail++; $display("FAIL fetch_rdata: got %h want 00100093", bus.if_rdata); end
    n_checks++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL fetch_d_quiet: got rvalid=%b rdata=%h want 0 0", bus.d_rvalid, bus.d_rdata); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_rvalid_drop: got %b want 0", bus.if_rvalid); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_write_mode = 3'b010;
    #1;
    n_checks++; if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin n_fail++; $display("FAIL wr_gnt: got if/d=%b want 01", {bus.if_gnt, bus.d_gnt}); end
    n_checks++; if (bus.sram_we !== 1'b1 || bus.sram_wdata !== 32'hDEAD_BEEF || bus.sram_write_mode !== 3'b010)
      begin n_fail++; $display("FAIL wr_sram: got we=%b wdata=%h wmode=%b want 1 deadbeef 010", bus.sram_we, bus.sram_wdata, bus.sram_write_mode); end
    @(negedge clk);
    bus.d_we = 1'b0; bus.d_wdata = '0; bus.d_write_mode = 3'b000; bus.d_mode = 3'b010;
    #1;
    n_checks++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", bus.d_gnt); end
    n_checks++; if (bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 0", bus.d_rvalid); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.d_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %b want 1", bus.d_rvalid); end
    n_checks++; if (bus.d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", bus.d_rdata); end
    n_checks++; if (bus.if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_if_quiet: got %b want 0", bus.if_rvalid); end
  endtask

  // Both ports request continuously for `cycles` cycles starting from a cleared counter.
  // Expected winner: IF on every fifth cycle (counter reaches 4 after four denials).
  task automatic contend(input string tag, input int cycles);
    logic prev_d;
    logic exp_d;
    prev_d = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      d_read(32'h4);
      #1;
      exp_d = ((c % 5) != 4);
      n_checks++; if ({bus.if_gnt, bus.d_gnt} !== {~exp_d, exp_d})
        begin n_fail++; $display("FAIL %s_gnt c%0d: got if/d=%b want %b", tag, c, {bus.if_gnt, bus.d_gnt}, {~exp_d, exp_d}); end
      if (c > 0) begin
        n_checks++; if ({bus.if_rvalid, bus.d_rvalid} !== {~prev_d, prev_d})
          begin n_fail++; $display("FAIL %s_rvalid c%0d: got if/d=%b want %b", tag, c, {bus.if_rvalid, bus.d_rvalid}, {~prev_d, prev_d}); end
      end
      prev_d = exp_d;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_contention();
    contend("contend", 10);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    #1;
    n_checks++; if (bus.if_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0: got %b want 1", bus.if_gnt); end
    @(negedge clk);
    bus.if_req = 1'b0;
    d_read(32'h4);
    #1;
    n_checks++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt1: got %b want 1", bus.d_gnt); end
    n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hAAAA_0000 || bus.d_rvalid !== 1'b0)
      begin n_fail++; $display("FAIL b2b_resp0: got if_rv=%b if_rd=%h d_rv=%b want 1 aaaa0000 0", bus.if_rvalid, bus.if_rdata, bus.d_rvalid); end
    @(negedge clk);
    idle_inputs();
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    #1;
    n_checks++; if (bus.if_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt2: got %b want 1", bus.if_gnt); end
    n_checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hBBBB_0004 || bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h0)
      begin n_fail++; $display("FAIL b2b_resp1: got d_rv=%b d_rd=%h if_rv=%b if_rd=%h want 1 bbbb0004 0 0", bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hCCCC_0008 || bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0)
      begin n_fail++; $display("FAIL b2b_resp2: got if_rv=%b if_rd=%h d_rv=%b d_rd=%h want 1 cccc0008 0 0", bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata); end
  endtask

  task automatic test_reset_mid_read();
    // Two contended cycles: data wins both, counter climbs to 2
    repeat (2) begin
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      d_read(32'h4);
    end
    @(posedge clk);
    #1;
    n_checks++; if (bus.d_rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_rvalid_pre: got %b want 1", bus.d_rvalid); end
    #1;
    reset = 1'b0;
    idle_inputs();
    #1;
    n_checks++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rvalid_drop: got rvalid=%b rdata=%h want 0 0", bus.d_rvalid, bus.d_rdata); end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      n_checks++; if ({bus.if_rvalid, bus.d_rvalid} !== 2'b00)
        begin n_fail++; $display("FAIL post_reset_quiet c%0d: got if/d rvalid=%b want 00", c, {bus.if_rvalid, bus.d_rvalid}); end
    end
    // A counter left at 2 would let fetch win on the third cycle instead of the fifth
    contend("post_reset", 5);
  endtask

  task automatic test_byte_passthrough();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h103;
    bus.d_mode = 3'b000; bus.d_us = 1'b1; bus.d_write_mode = 3'b000;
    #1;
    n_checks++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL byte_gnt: got %b want 1", bus.d_gnt); end
    n_checks++; if (bus.sram_mode !== 3'b000 || bus.sram_us !== 1'b1 || bus.sram_addr !== 32'h103)
      begin n_fail++; $display("FAIL byte_fields: got mode=%b us=%b addr=%h want 000 1 103", bus.sram_mode, bus.sram_us, bus.sram_addr); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.d_rvalid !== 1'b1) begin n_fail++; $display("FAIL byte_rvalid: got %b want 1", bus.d_rvalid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'hAAAA_0000;
    mem[1] = 32'hBBBB_0004;
    mem[2] = 32'hCCCC_0008;
    mem[4] = 32'h0010_0093;
    bus.sram_rdata = '0;

    test_reset();
    test_fetch();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_reset_mid_read();
    test_byte_passthrough();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
